alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8: datapath width in bits; legal range 4..32.
REQ-002 Parameter MUL_EN, default 1: when 0, MUL is a NOP and stall is never asserted.
REQ-003 tclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 instruction  input  8  opcode in [7:4]; function bits in [1:0].
REQ-006 state  input  2  CPU cycle: FETCH=00, DECODE=01, EXEC_A=10, EXEC_B=11.
REQ-007 acc  output  WIDTH  accumulator, registered.
REQ-008 latch  output  WIDTH  copy of the last ALU result, registered.
REQ-009 hi  output  WIDTH  upper half of the last MUL product, registered.
REQ-010 c, z, n, v  output  1 each  carry/borrow, zero, negative and signed-overflow flags, registered.
REQ-011 stall  output  1  CPU SHALL hold state at EXEC_B while high; combinational.
REQ-012 d_bus  inout  WIDTH  shared data bus; high-impedance unless driven per REQ-026.

Function
REQ-013 Opcodes SHALL be: 0000 ADD, 0001 ADC, 0010 SUB, 0011 SBC, 0100 NAND, 0101 XOR, 0110 SHIFT, 0111 MUL, 1000 LD, 1010 ST; all others are NOP (no state change).
REQ-014 LD SHALL capture d_bus into acc at the EXEC_A edge; flags unchanged.
REQ-015 ALU ops (ADD..MUL) SHALL execute only when state=EXEC_B; operand B is d_bus sampled on the first EXEC_B edge.
REQ-016 Single-cycle ops SHALL write the result to both acc and latch at the EXEC_B edge; stall stays 0.
REQ-017 ADD/ADC: result = acc+B(+c), modulo 2^WIDTH; c = carry out; v = signed overflow.
REQ-018 SUB/SBC: result = acc-B(-c), modulo 2^WIDTH; c = borrow (1 when the unsigned result is negative); v = signed overflow.
REQ-019 NAND/XOR: bitwise; c and v are cleared.
REQ-020 SHIFT uses acc only; instruction[0]=1 right, 0 left; instruction[1]=1 rotates through c, 0 shifts in 0; c = bit shifted out; v cleared.
REQ-021 For all ALU ops: z = (result==0); n = result[WIDTH-1].
REQ-022 MUL is an unsigned shift-add sequencer with states IDLE, RUN, DONE and a bit counter (0..WIDTH-1).
REQ-023 IDLE with opcode=MUL and state=EXEC_B: stall=1; at the edge, capture acc and B, clear the partial product, and go to RUN.
REQ-024 RUN: stall=1; one multiplier bit per cycle for WIDTH cycles. On the last RUN edge: acc=latch=product[WIDTH-1:0], hi=product[2W-1:W], c=(hi!=0), z=(product==0), n=acc MSB, v=0; then go to DONE.
REQ-025 DONE: stall=0; return to IDLE on the next edge unconditionally. A MUL therefore occupies EXEC_B for WIDTH+2 cycles.
REQ-026 d_bus SHALL be driven with acc only when state=EXEC_B and opcode=ST; ST changes no register.
REQ-027 If state leaves EXEC_B while in RUN (protocol violation): abort to IDLE, with no write to acc, latch, hi or flags.
REQ-028 hi SHALL change only on MUL completion.

Reset
REQ-029 While reset=1 at an edge: acc, latch and hi = 0; c, z, n and v = 0; MUL state = IDLE with counter 0.
REQ-030 Reset SHALL take priority over every operation, including mid-MUL; stall=0 in the first cycle after reset.
REQ-031 d_bus SHALL be high-impedance while reset is high.

Verification (WIDTH=8)
REQ-032 LD 0x7F, then ADD with d_bus=0x01 -> acc=latch=0x80, c=0, z=0, n=1, v=1.
REQ-033 acc=0x10, SUB with B=0x10 -> acc=0x00, z=1, c=0; then SUB with B=0x01 -> acc=0xFF, c=1, n=1.
REQ-034 acc=0xFF, MUL with B=0xFF -> stall high for 9 cycles, low in the DONE cycle; result acc=0x01, hi=0xFE, c=1, z=0.
REQ-035 c=1, acc=0x02, SHIFT with instruction[1:0]=11 -> acc=0x81, c=0, n=1.
REQ-036 acc=0x5A, ST at EXEC_B -> d_bus=0x5A; d_bus is Z in FETCH, DECODE and EXEC_A.
REQ-037 reset pulsed during the 4th RUN cycle of a MUL -> next cycle all registers are 0, stall=0, and acc/hi are not written.

Source files
------------

// File: rtl/alu_seq_if.sv
// ============================================================================
//  Module   : alu_seq_if
//  Brief    : CPU-side control and result signals of the sequenced ALU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       instruction;
    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] latch;
    logic [WIDTH-1:0] hi;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
    logic             stall;

    modport master (
        output instruction, state,
        input  acc, latch, hi, c, z, n, v, stall
    );

    modport slave (
        input  instruction, state,
        output acc, latch, hi, c, z, n, v, stall
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module   : alu_seq
//  Brief    : Accumulator ALU with single-cycle ops and a shift-add multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  wire logic             tclk,
    input  wire logic             reset,
    alu_seq_if.slave              bus,
    inout  wire       [WIDTH-1:0] d_bus
);
    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam bit c_MUL_ON = (MUL_EN != 0);

    localparam logic [1:0] c_EXEC_A = 2'b10;
    localparam logic [1:0] c_EXEC_B = 2'b11;

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_ADC   = 4'h1;
    localparam logic [3:0] c_OP_SUB   = 4'h2;
    localparam logic [3:0] c_OP_SBC   = 4'h3;
    localparam logic [3:0] c_OP_NAND  = 4'h4;
    localparam logic [3:0] c_OP_XOR   = 4'h5;
    localparam logic [3:0] c_OP_SHIFT = 4'h6;
    localparam logic [3:0] c_OP_MUL   = 4'h7;
    localparam logic [3:0] c_OP_LD    = 4'h8;
    localparam logic [3:0] c_OP_ST    = 4'hA;

    localparam logic [1:0] c_M_IDLE = 2'd0;
    localparam logic [1:0] c_M_RUN  = 2'd1;
    localparam logic [1:0] c_M_DONE = 2'd2;

    logic [WIDTH-1:0]   r_acc, r_latch, r_hi, r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_c, r_z, r_n, r_v;
    logic [1:0]         r_mstate, w_mstate_next;
    logic [c_CW-1:0]    r_cnt, w_cnt_next;

    logic [3:0]         w_op;
    logic               w_exec_a, w_exec_b, w_mul_req;
    logic               w_stall, w_mul_start, w_mul_step, w_mul_finish;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_sum, w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH-1:0]   w_res;
    logic               w_c_new, w_v_new, w_alu, w_alu_exec;
    logic [1:0]         w_unused;

    assign w_op      = bus.instruction[7:4];
    assign w_unused  = bus.instruction[3:2];
    assign w_exec_a  = (bus.state == c_EXEC_A);
    assign w_exec_b  = (bus.state == c_EXEC_B);
    assign w_b       = d_bus;
    assign w_mul_req = c_MUL_ON && w_exec_b && (w_op == c_OP_MUL);

    // Multiplier FSM: state register
    always_ff @(posedge tclk) begin
        if (reset) begin
            r_mstate <= c_M_IDLE;
            r_cnt    <= '0;
        end else begin
            r_mstate <= w_mstate_next;
            r_cnt    <= w_cnt_next;
        end
    end

    // Multiplier FSM: next state; leaving EXEC_B mid-run abandons the product
    always_comb begin
        w_mstate_next = r_mstate;
        w_cnt_next    = r_cnt;
        case (r_mstate)
            c_M_IDLE: begin
                if (w_mul_req) begin
                    w_mstate_next = c_M_RUN;
                    w_cnt_next    = '0;
                end
            end
            c_M_RUN: begin
                if (!w_exec_b) begin
                    w_mstate_next = c_M_IDLE;
                    w_cnt_next    = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_mstate_next = c_M_DONE;
                    w_cnt_next    = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_M_DONE: w_mstate_next = c_M_IDLE;
            default:  w_mstate_next = c_M_IDLE;
        endcase
    end

    // Multiplier FSM: outputs
    always_comb begin
        w_stall      = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;
        w_mul_finish = 1'b0;
        case (r_mstate)
            c_M_IDLE: begin
                w_stall     = w_mul_req;
                w_mul_start = w_mul_req;
            end
            c_M_RUN: begin
                w_stall      = 1'b1;
                w_mul_step   = w_exec_b;
                w_mul_finish = w_exec_b && (r_cnt == c_CNT_LAST);
            end
            default: ;
        endcase
    end

    // Right-shifting shift-add: low half starts as the multiplier, LSB selects the add
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    always_comb begin
        w_sum   = '0;
        w_res   = r_acc;
        w_c_new = r_c;
        w_v_new = r_v;
        w_alu   = 1'b0;
        case (w_op)
            c_OP_ADD, c_OP_ADC: begin
                w_sum   = {1'b0, r_acc} + {1'b0, w_b}
                        + {{WIDTH{1'b0}}, (w_op == c_OP_ADC) & r_c};
                w_res   = w_sum[WIDTH-1:0];
                w_c_new = w_sum[WIDTH];
                w_v_new = (r_acc[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != r_acc[WIDTH-1]);
                w_alu   = 1'b1;
            end
            c_OP_SUB, c_OP_SBC: begin
                w_sum   = {1'b0, r_acc} - {1'b0, w_b}
                        - {{WIDTH{1'b0}}, (w_op == c_OP_SBC) & r_c};
                w_res   = w_sum[WIDTH-1:0];
                w_c_new = w_sum[WIDTH];
                w_v_new = (r_acc[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != r_acc[WIDTH-1]);
                w_alu   = 1'b1;
            end
            c_OP_NAND: begin
                w_res   = ~(r_acc & w_b);
                w_c_new = 1'b0;
                w_v_new = 1'b0;
                w_alu   = 1'b1;
            end
            c_OP_XOR: begin
                w_res   = r_acc ^ w_b;
                w_c_new = 1'b0;
                w_v_new = 1'b0;
                w_alu   = 1'b1;
            end
            c_OP_SHIFT: begin
                if (bus.instruction[0]) begin
                    w_res   = {bus.instruction[1] & r_c, r_acc[WIDTH-1:1]};
                    w_c_new = r_acc[0];
                end else begin
                    w_res   = {r_acc[WIDTH-2:0], bus.instruction[1] & r_c};
                    w_c_new = r_acc[WIDTH-1];
                end
                w_v_new = 1'b0;
                w_alu   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_alu_exec = w_alu && w_exec_b && (r_mstate != c_M_RUN);

    always_ff @(posedge tclk) begin
        if (reset) begin
            r_acc   <= '0;
            r_latch <= '0;
            r_hi    <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            if (w_exec_a && (w_op == c_OP_LD)) begin
                r_acc <= w_b;
            end
            if (w_alu_exec) begin
                r_acc   <= w_res;
                r_latch <= w_res;
                r_c     <= w_c_new;
                r_v     <= w_v_new;
                r_z     <= (w_res == '0);
                r_n     <= w_res[WIDTH-1];
            end
            if (w_mul_start) begin
                r_mcand <= r_acc;
                r_prod  <= {{WIDTH{1'b0}}, w_b};
            end
            if (w_mul_step) begin
                r_prod <= w_prod_next;
            end
            if (w_mul_finish) begin
                r_acc   <= w_prod_next[WIDTH-1:0];
                r_latch <= w_prod_next[WIDTH-1:0];
                r_hi    <= w_prod_next[2*WIDTH-1:WIDTH];
                r_c     <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
                r_z     <= (w_prod_next == '0);
                r_n     <= w_prod_next[WIDTH-1];
                r_v     <= 1'b0;
            end
        end
    end

    assign d_bus = (!reset && w_exec_b && (w_op == c_OP_ST)) ? r_acc : 'z;

    assign bus.acc   = r_acc;
    assign bus.latch = r_latch;
    assign bus.hi    = r_hi;
    assign bus.c     = r_c;
    assign bus.z     = r_z;
    assign bus.n     = r_n;
    assign bus.v     = r_v;
    assign bus.stall = w_stall;
endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module   : tb_alu_seq
//  Brief    : Directed, scoreboarded bench for alu_seq at WIDTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
    localparam int W = 8;

    logic tclk = 1'b0;
    logic reset = 1'b1;
    always #5 tclk = ~tclk;

    alu_seq_if #(.WIDTH(W)) bus ();
    wire  [W-1:0] d_bus;
    logic [W-1:0] drv;
    logic         drv_en;
    assign d_bus = drv_en ? drv : 'z;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .tclk  (tclk),
        .reset (reset),
        .bus   (bus),
        .d_bus (d_bus)
    );

    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] latch;
        logic [7:0] hi;
        logic [3:0] flags;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] m_acc, m_latch, m_hi;
    logic       m_c, m_z, m_n, m_v;

    task automatic tick();
        @(posedge tclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_latch = 0; m_hi = 0;
        m_c = 0; m_z = 0; m_n = 0; m_v = 0;
    endtask

    task automatic push_model();
        exp_t e;
        e.acc   = m_acc;
        e.latch = m_latch;
        e.hi    = m_hi;
        e.flags = {m_c, m_z, m_n, m_v};
        sb.push_back(e);
    endtask

    task automatic check_regs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".acc"},   32'(bus.acc),   32'(e.acc));
            check({tag, ".latch"}, 32'(bus.latch), 32'(e.latch));
            check({tag, ".hi"},    32'(bus.hi),    32'(e.hi));
            check({tag, ".czn_v"}, 32'({bus.c, bus.z, bus.n, bus.v}), 32'(e.flags));
        end
    endtask

    // Behavioural reference using plain integer arithmetic
    task automatic model_op(input logic [7:0] instr, input logic [7:0] b);
        int a, bb, ci, t, s, res;
        bit upd;
        a = int'(m_acc); bb = int'(b); ci = 0; res = 0; upd = 1;
        case (instr[7:4])
            4'h0, 4'h1: begin
                ci = (instr[7:4] == 4'h1) ? int'(m_c) : 0;
                t = a + bb + ci;
                s = int'($signed(m_acc)) + int'($signed(b)) + ci;
                res = t % 256; m_c = (t > 255); m_v = (s > 127) || (s < -128);
            end
            4'h2, 4'h3: begin
                ci = (instr[7:4] == 4'h3) ? int'(m_c) : 0;
                t = a - bb - ci;
                s = int'($signed(m_acc)) - int'($signed(b)) - ci;
                res = (t + 512) % 256; m_c = (t < 0); m_v = (s > 127) || (s < -128);
            end
            4'h4: begin res = (~(a & bb)) & 255; m_c = 0; m_v = 0; end
            4'h5: begin res = (a ^ bb) & 255;    m_c = 0; m_v = 0; end
            4'h6: begin
                ci = (instr[1] && m_c) ? 1 : 0;
                if (instr[0]) begin res = (a >> 1) + ci * 128;        m_c = a[0]; end
                else          begin res = ((a << 1) & 255) + ci;      m_c = a[7]; end
                m_v = 0;
            end
            4'h7: begin
                t = a * bb;
                m_acc = t[7:0]; m_latch = t[7:0]; m_hi = t[15:8];
                m_c = (t[15:8] != 0); m_z = (t == 0); m_n = t[7]; m_v = 0;
                upd = 0;
            end
            4'h8: begin m_acc = b; upd = 0; end
            default: upd = 0;
        endcase
        if (upd) begin
            m_acc = res[7:0]; m_latch = res[7:0];
            m_z = (res == 0); m_n = res[7];
        end
    endtask

    task automatic exec(input logic [7:0] instr, input logic [7:0] b, input string tag);
        int n, exp_n;
        model_op(instr, b);
        push_model();
        exp_n = (instr[7:4] == 4'h7) ? W + 1 : 0;
        bus.instruction = instr;
        drv = b; drv_en = 1'b1;
        bus.state = 2'b10;
        tick();
        bus.state = 2'b11;
        #1;
        n = 0;
        while (bus.stall && n < 40) begin
            n++;
            tick();
            if (n == 1) drv = ~b;
        end
        check({tag, ".stall_cycles"}, 32'(n), 32'(exp_n));
        tick();
        drv_en = 1'b0;
        bus.state = 2'b00;
        bus.instruction = 8'hF0;
        #1;
        check_regs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        drv = '0; drv_en = 1'b0;
        bus.instruction = 8'hF0;
        bus.state = 2'b00;
        reset = 1'b1;
        tick(); tick();
        model_reset();
        push_model();
        check_regs("reset");
        check("reset.stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;
        tick();

        exec(8'h80, 8'h7F, "ld_7f");
        exec(8'h00, 8'h01, "add_ovf");
        exec(8'h80, 8'h10, "ld_10");
        exec(8'h20, 8'h10, "sub_zero");
        exec(8'h20, 8'h01, "sub_borrow");
        exec(8'h30, 8'h00, "sbc");
        exec(8'h80, 8'hFF, "ld_ff");
        exec(8'h00, 8'h01, "add_carry");
        exec(8'h10, 8'h00, "adc");
        exec(8'h40, 8'h0F, "nand");
        exec(8'h50, 8'hFF, "xor");

        exec(8'h80, 8'hFF, "ld_ff2");
        exec(8'h70, 8'hFF, "mul_ff");

        exec(8'h80, 8'hFF, "ld_ff3");
        exec(8'h00, 8'h03, "add_setc");
        exec(8'h63, 8'h00, "ror_c");
        exec(8'h60, 8'h00, "shl");
        exec(8'h62, 8'h00, "rol_c");
        exec(8'h80, 8'h03, "ld_03");
        exec(8'h70, 8'h05, "mul_small");

        exec(8'h80, 8'h5A, "ld_5a");
        bus.instruction = 8'hA0;
        drv_en = 1'b1; drv = 8'hA5;
        for (int s = 0; s < 3; s++) begin
            bus.state = 2'(s);
            #1;
            check($sformatf("st.probe%0d", s), 32'(d_bus), 32'hA5);
            tick();
        end
        bus.state = 2'b11;
        drv_en = 1'b0;
        #1;
        check("st.drive", 32'(d_bus), 32'h5A);
        tick();
        bus.state = 2'b00;
        bus.instruction = 8'hF0;
        push_model();
        check_regs("st");

        exec(8'hF0, 8'h33, "nop_f");
        exec(8'h90, 8'h33, "nop_9");

        // Leave EXEC_B two cycles into a multiply: nothing may be written
        exec(8'h80, 8'h0F, "ld_0f");
        bus.instruction = 8'h70;
        drv = 8'h0F; drv_en = 1'b1;
        bus.state = 2'b11;
        tick(); tick(); tick();
        bus.state = 2'b00;
        drv_en = 1'b0;
        tick();
        check("abort.stall", 32'(bus.stall), 32'd0);
        push_model();
        check_regs("abort");
        exec(8'h00, 8'h01, "add_after_abort");
        exec(8'h70, 8'h03, "mul_after_abort");

        // Reset during the fourth RUN cycle
        exec(8'h80, 8'hFF, "ld_ff4");
        bus.instruction = 8'h70;
        drv = 8'h02; drv_en = 1'b1;
        bus.state = 2'b11;
        repeat (4) tick();
        check("rst_mul.stall_run", 32'(bus.stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.state = 2'b00;
        drv_en = 1'b0;
        #1;
        model_reset();
        push_model();
        check_regs("rst_mul");
        check("rst_mul.stall", 32'(bus.stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
